// File: rtl/reg_pkg.sv
// Shared types and helpers for the reg_file_nrw register file: address-width function,
// byte-lane merge and default geometry.
package reg_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_DEPTH = 16;
    // Widest entry merge_bytes can handle; callers zero-extend into it and truncate back.
    localparam int unsigned MAX_WIDTH = 512;
    localparam int unsigned MAX_BYTES = MAX_WIDTH / 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] merge_bytes(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_BYTES-1:0] be
    );
        logic [MAX_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < int'(MAX_BYTES); i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reg_word.sv
// One register-file entry: byte-enabled storage with synchronous reset and a
// written-since-reset flag.
module reg_word
    import reg_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wbe,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [WIDTH-1:0] w_merged;

    assign w_merged = WIDTH'(merge_bytes(MAX_WIDTH'(r_data), MAX_WIDTH'(i_wdata),
                                         MAX_BYTES'(i_wbe)));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_we && (|i_wbe)) begin
            r_data  <= w_merged;
            r_valid <= 1'b1;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/reg_file_nrw.sv
// DEPTH x WIDTH register file, one byte-enabled write port and two combinational read ports
// with optional write-to-read bypass and hardwired-zero entry 0.
module reg_file_nrw
    import reg_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1,
    localparam int unsigned AW      = clog2(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic [WIDTH/8-1:0] i_wbe,
    input  logic [AW-1:0]      i_raddr_a,
    output logic [WIDTH-1:0]   o_rdata_a,
    output logic               o_rvalid_a,
    input  logic [AW-1:0]      i_raddr_b,
    output logic [WIDTH-1:0]   o_rdata_b,
    output logic               o_rvalid_b
);

    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_valid;

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_entry
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign w_data[i]  = '0;
            assign w_valid[i] = 1'b1;
        end else begin : g_word
            reg_word #(
                .WIDTH (WIDTH)
            ) u_word (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_we    (i_we && (i_waddr == AW'(i))),
                .i_wdata (i_wdata),
                .i_wbe   (i_wbe),
                .o_data  (w_data[i]),
                .o_valid (w_valid[i])
            );
        end
    end

    logic             w_wr_zero;
    logic             w_byp_en;
    logic [WIDTH-1:0] w_byp_data;
    logic             w_byp_valid;

    // Bypass is held off during reset so the stored (pre-reset) value stays visible.
    assign w_wr_zero   = ZERO_REG && (i_waddr == '0);
    assign w_byp_en    = BYPASS && i_we && !i_rst && !w_wr_zero;
    assign w_byp_data  = WIDTH'(merge_bytes(MAX_WIDTH'(w_data[i_waddr]), MAX_WIDTH'(i_wdata),
                                            MAX_BYTES'(i_wbe)));
    assign w_byp_valid = w_valid[i_waddr] | (|i_wbe);

    always_comb begin
        o_rdata_a  = w_data[i_raddr_a];
        o_rvalid_a = w_valid[i_raddr_a];
        o_rdata_b  = w_data[i_raddr_b];
        o_rvalid_b = w_valid[i_raddr_b];
        if (w_byp_en && (i_raddr_a == i_waddr)) begin
            o_rdata_a  = w_byp_data;
            o_rvalid_a = w_byp_valid;
        end
        if (w_byp_en && (i_raddr_b == i_waddr)) begin
            o_rdata_b  = w_byp_data;
            o_rvalid_b = w_byp_valid;
        end
    end

endmodule

// File: tb/tb_reg_file_nrw.sv
// Bench for reg_file_nrw: four configurations share one stimulus stream, each checked every
// cycle against a byte-level array model, plus hand-computed directed expectations.
module tb_reg_file_nrw;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [7:0]  waddr;
    logic [7:0]  raddr_a;
    logic [7:0]  raddr_b;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic        chk_en = 1'b0;
    int          n_vec  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // cfg0: 32x16 zero+bypass, cfg1: 32x16 plain, cfg2: 8x2 zero+bypass, cfg3: 64x32 bypass
    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int unsigned W  = (g == 2) ? 8 : (g == 3) ? 64 : 32;
        localparam int unsigned D  = (g == 2) ? 2 : (g == 3) ? 32 : 16;
        localparam bit          ZR = (g == 0) || (g == 2);
        localparam bit          BP = (g != 1);
        localparam int unsigned AW = $clog2(D);
        localparam int unsigned NB = W / 8;

        logic [W-1:0]  rd_a, rd_b;
        logic          rv_a, rv_b;
        logic [AW-1:0] wa, ra, rb;
        logic [W-1:0]  wd;
        logic [NB-1:0] be;

        logic [W-1:0]  mem [D];
        bit            vld [D];
        logic [AW-1:0] a;
        logic [W-1:0]  ed;
        logic          ev;

        assign wa = waddr[AW-1:0];
        assign ra = raddr_a[AW-1:0];
        assign rb = raddr_b[AW-1:0];
        assign wd = wdata[W-1:0];
        assign be = wbe[NB-1:0];

        reg_file_nrw #(
            .WIDTH    (W),
            .DEPTH    (D),
            .ZERO_REG (ZR),
            .BYPASS   (BP)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_we       (we),
            .i_waddr    (wa),
            .i_wdata    (wd),
            .i_wbe      (be),
            .i_raddr_a  (ra),
            .o_rdata_a  (rd_a),
            .o_rvalid_a (rv_a),
            .i_raddr_b  (rb),
            .o_rdata_b  (rd_b),
            .o_rvalid_b (rv_b)
        );

        always @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d < int'(D); d++) begin
                    mem[d] = '0;
                    vld[d] = ZR && (d == 0);
                end
            end else if (we && (be != 0) && !(ZR && (wa == 0))) begin
                for (int k = 0; k < int'(NB); k++) begin
                    if (be[k]) mem[wa][8*k +: 8] = wd[8*k +: 8];
                end
                vld[wa] = 1'b1;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                for (int p = 0; p < 2; p++) begin
                    a  = (p == 1) ? rb : ra;
                    ed = mem[a];
                    ev = vld[a];
                    if (BP && we && !rst && (a == wa) && !(ZR && (a == 0))) begin
                        for (int k = 0; k < int'(NB); k++) begin
                            if (be[k]) ed[8*k +: 8] = wd[8*k +: 8];
                        end
                        ev = ev || (be != 0);
                    end
                    check($sformatf("cfg%0d_port%s_data", g, (p == 1) ? "b" : "a"),
                          64'((p == 1) ? rd_b : rd_a), 64'(ed));
                    check($sformatf("cfg%0d_port%s_valid", g, (p == 1) ? "b" : "a"),
                          64'((p == 1) ? rv_b : rv_a), 64'(ev));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic w, input int wa, input logic [63:0] wd,
                         input logic [7:0] b, input int ra, input int rb);
        rst     = r;
        we      = w;
        waddr   = 8'(wa);
        wdata   = wd;
        wbe     = b;
        raddr_a = 8'(ra);
        raddr_b = 8'(rb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 0, 64'h0, 8'h0, 0, 0);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 0, 0);
        chk_en = 1'b1;

        // Reset sweep
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, i, 64'hDEAD_BEEF, 8'hFF, i, i);
            tick();
        end
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 5, 5);
        @(negedge clk);
        check("fill_e5_data", 64'(g_cfg[0].rd_a), 64'hDEAD_BEEF);
        check("fill_e5_valid", 64'(g_cfg[0].rv_a), 64'd1);
        tick();
        drive(1'b1, 1'b0, 0, 64'h0, 8'h0, 0, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b0, 0, 64'h0, 8'h0, i, 15 - i);
            @(negedge clk);
            check("sweep_data_a", 64'(g_cfg[0].rd_a), 64'h0);
            check("sweep_valid_a", 64'(g_cfg[0].rv_a), (i == 0) ? 64'd1 : 64'd0);
            check("sweep_valid_b", 64'(g_cfg[0].rv_b), (i == 15) ? 64'd1 : 64'd0);
            tick();
        end

        // Byte enables
        drive(1'b0, 1'b1, 5, 64'h1122_3344, 8'h0F, 5, 5);
        tick();
        drive(1'b0, 1'b1, 5, 64'hAABB_CCDD, 8'h05, 5, 5);
        @(negedge clk);
        check("be_bypass_cfg0", 64'(g_cfg[0].rd_a), 64'h11BB_33DD);
        check("be_nobypass_cfg1", 64'(g_cfg[1].rd_a), 64'h1122_3344);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 5, 5);
        @(negedge clk);
        check("be_after_cfg0", 64'(g_cfg[0].rd_a), 64'h11BB_33DD);
        check("be_after_cfg1", 64'(g_cfg[1].rd_b), 64'h11BB_33DD);
        check("be_after_valid", 64'(g_cfg[0].rv_a), 64'd1);
        tick();

        // Bypass on both ports
        drive(1'b0, 1'b1, 7, 64'h1234_5678, 8'h0F, 7, 7);
        @(negedge clk);
        check("byp_a_cfg0", 64'(g_cfg[0].rd_a), 64'h1234_5678);
        check("byp_b_cfg0", 64'(g_cfg[0].rd_b), 64'h1234_5678);
        check("byp_valid_cfg0", 64'(g_cfg[0].rv_a), 64'd1);
        check("nobyp_a_cfg1", 64'(g_cfg[1].rd_a), 64'h0);
        check("nobyp_valid_cfg1", 64'(g_cfg[1].rv_a), 64'd0);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 7, 7);
        @(negedge clk);
        check("nobyp_after_cfg1", 64'(g_cfg[1].rd_a), 64'h1234_5678);
        tick();

        // Zero register
        drive(1'b0, 1'b1, 0, 64'hFFFF_FFFF, 8'h0F, 0, 0);
        @(negedge clk);
        check("zero_byp_cfg0", 64'(g_cfg[0].rd_a), 64'h0);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 0, 0);
        @(negedge clk);
        check("zero_cfg0", 64'(g_cfg[0].rd_a), 64'h0);
        check("zero_valid_cfg0", 64'(g_cfg[0].rv_a), 64'd1);
        check("nozero_cfg1", 64'(g_cfg[1].rd_a), 64'hFFFF_FFFF);
        tick();

        // we with wbe=0 is a no-op
        drive(1'b0, 1'b1, 9, 64'h55, 8'h00, 9, 9);
        @(negedge clk);
        check("wbe0_byp_valid", 64'(g_cfg[0].rv_a), 64'd0);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 9, 9);
        @(negedge clk);
        check("wbe0_after_valid", 64'(g_cfg[0].rv_a), 64'd0);
        tick();

        // Reset/write collision
        drive(1'b0, 1'b1, 3, 64'h0BAD_BEEF, 8'h0F, 3, 3);
        tick();
        drive(1'b1, 1'b1, 3, 64'hCAFE_F00D, 8'h0F, 3, 3);
        @(negedge clk);
        check("coll_during_data", 64'(g_cfg[0].rd_a), 64'h0BAD_BEEF);
        check("coll_during_valid", 64'(g_cfg[0].rv_a), 64'd1);
        tick();
        drive(1'b0, 1'b0, 0, 64'h0, 8'h0, 3, 3);
        @(negedge clk);
        check("coll_after_data", 64'(g_cfg[0].rd_a), 64'h0);
        check("coll_after_valid", 64'(g_cfg[0].rv_a), 64'd0);
        tick();

        // Random regression
        for (int n = 0; n < 10000; n++) begin
            rst     = ($urandom_range(63) == 0);
            we      = 1'($urandom_range(1));
            waddr   = 8'($urandom);
            raddr_a = ($urandom_range(3) == 0) ? waddr : 8'($urandom);
            raddr_b = ($urandom_range(3) == 0) ? waddr : 8'($urandom);
            wdata   = {$urandom, $urandom};
            wbe     = 8'($urandom);
            tick();
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
